// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the digit-serial adder/subtractor
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit combinational full-adder cell
module full_adder_cell (
    output logic s,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial WIDTH-bit add/sub with start/busy/done handshake
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_sub
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;
    logic [WIDTH-1:0] sum_next;

    assign c[0] = carry;

    genvar i;
    generate
        for (i = 0; i < DIGIT; i++) begin : g_chain
            full_adder_cell u_cell (
                .s    (s[i]),
                .c_out(c[i+1]),
                .a    (a_sh[i]),
                .b    (b_sh[i]),
                .c_in (c[i])
            );
        end
    endgenerate

    // New digit enters at the MSB end so the LSB digit lands at bit 0 after N shifts.
    generate
        if (DIGIT == WIDTH) begin : g_sum_full
            assign sum_next = s;
        end else begin : g_sum_shift
            assign sum_next = {s, sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    sum   <= sum_next;
                    carry <= c[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        c_out <= c[DIGIT];
`ifdef SERIAL_ADD_OVF_EN
                        // Last digit holds the MSB, so its top two chain carries bracket it.
                        ovf   <= c[DIGIT] ^ c[DIGIT-1];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
